wb_line_refill_master: RTL and testbench

- Wishbone B4 master between the instruction/data cache controller and the external memory port.
- Converts a cache line-fill request into an incrementing burst read of BEATS words.
- Converts a single-word store request into a classic single write cycle.
- Streams returned words to the cache with a word index and reports completion or error (bus error, exhausted retries, or ack timeout).

---
 rtl/wb_line_refill_master.sv | 192 +++++++++++++++++++
 tb/tb_wb_line_refill_master.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_line_refill_master.sv
// Wishbone B4 master: turns cache line fills into incrementing bursts and
// single-word stores into classic write cycles, with retry/error/timeout handling.
//
// state     | meaning
// IDLE      | waiting for a request, req_ready high
// RD_BURST  | incrementing burst read of one cache line in progress
// WR_SINGLE | classic single write cycle in progress
// RETRY_GAP | one idle bus cycle after rty before restarting the request
// FINISH    | request over, done/err are issued on the following cycle
module wb_line_refill_master #(
  parameter int BEATS     = 8,
  parameter int TIMEOUT   = 64,
  parameter int MAX_RETRY = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  input  logic [3:0]               req_sel,
  output logic                     fill_valid,
  output logic [$clog2(BEATS)-1:0] fill_idx,
  output logic [31:0]              fill_data,
  output logic                     done,
  output logic                     err,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  output logic                     wb_we_o,
  output logic [31:0]              wb_adr_o,
  output logic [3:0]               wb_sel_o,
  output logic [31:0]              wb_dat_o,
  output logic [2:0]               wb_cti_o,
  output logic [1:0]               wb_bte_o,
  input  logic [31:0]              wb_dat_i,
  input  logic                     wb_ack_i,
  input  logic                     wb_err_i,
  input  logic                     wb_rty_i
);

  localparam int IW = $clog2(BEATS);
  localparam int OW = IW + 2;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_BURST  = 3'd1,
    WR_SINGLE = 3'd2,
    RETRY_GAP = 3'd3,
    FINISH    = 3'd4
  } state_t;

  state_t state, state_n;

  logic [IW-1:0] beat;
  logic [TW-1:0] tmo_cnt;
  logic [RW-1:0] retry_cnt;
  logic          abort_q;
  logic          lat_we;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wdata;
  logic [3:0]    lat_sel;

  logic          accept, launch, data_st, retry_max, tmo_hit, last_beat;
  logic          l_we;
  logic [31:0]   l_addr, l_wdata;
  logic [3:0]    l_sel;

  // done is held off the ready path so a new request lands after the pulse
  assign req_ready = (state == IDLE) && !done;
  assign accept    = req_valid && req_ready;
  assign launch    = accept || (state == RETRY_GAP);
  assign data_st   = (state == RD_BURST) || (state == WR_SINGLE);
  assign retry_max = (retry_cnt == RW'(MAX_RETRY));
  assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT - 1));
  assign last_beat = (beat == IW'(BEATS - 1));
  assign wb_bte_o  = 2'b00;

  // Request fields come from the port on accept, from the latch on restart.
  assign l_we    = accept ? req_we : lat_we;
  assign l_addr  = accept ? (req_we ? req_addr : {req_addr[31:OW], {OW{1'b0}}}) : lat_addr;
  assign l_wdata = accept ? req_wdata : lat_wdata;
  assign l_sel   = accept ? req_sel : lat_sel;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (accept) state_n = req_we ? WR_SINGLE : RD_BURST;
      end
      RD_BURST, WR_SINGLE: begin
        if (wb_err_i)      state_n = FINISH;
        else if (wb_rty_i) state_n = retry_max ? FINISH : RETRY_GAP;
        else if (wb_ack_i) begin
          if ((state == WR_SINGLE) || last_beat) state_n = FINISH;
        end
        else if (tmo_hit)  state_n = FINISH;
      end
      RETRY_GAP: state_n = lat_we ? WR_SINGLE : RD_BURST;
      FINISH:    state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_adr_o   <= 32'h0;
      wb_sel_o   <= 4'h0;
      wb_dat_o   <= 32'h0;
      wb_cti_o   <= 3'b000;
      fill_valid <= 1'b0;
      fill_idx   <= '0;
      fill_data  <= 32'h0;
      done       <= 1'b0;
      err        <= 1'b0;
      beat       <= '0;
      tmo_cnt    <= '0;
      retry_cnt  <= '0;
      abort_q    <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= 32'h0;
      lat_wdata  <= 32'h0;
      lat_sel    <= 4'h0;
    end else begin
      fill_valid <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      if (launch) begin
        if (accept) begin
          lat_we    <= l_we;
          lat_addr  <= l_addr;
          lat_wdata <= l_wdata;
          lat_sel   <= l_sel;
          retry_cnt <= '0;
          abort_q   <= 1'b0;
        end
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
        wb_we_o  <= l_we;
        wb_adr_o <= l_addr;
        wb_sel_o <= l_we ? l_sel : 4'hF;
        wb_dat_o <= l_we ? l_wdata : 32'h0;
        wb_cti_o <= l_we ? 3'b000 : 3'b010;
        beat     <= '0;
        tmo_cnt  <= '0;
      end else if (data_st) begin
        tmo_cnt <= (wb_err_i || wb_rty_i || wb_ack_i) ? '0 : tmo_cnt + TW'(1);
        if (wb_err_i || wb_rty_i || (wb_ack_i && ((state == WR_SINGLE) || last_beat)) ||
            (!wb_ack_i && tmo_hit)) begin
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          wb_we_o  <= 1'b0;
          wb_cti_o <= 3'b000;
        end
        if (wb_err_i) begin
          abort_q <= 1'b1;
        end else if (wb_rty_i) begin
          if (retry_max) abort_q <= 1'b1;
          else           retry_cnt <= retry_cnt + RW'(1);
        end else if (wb_ack_i) begin
          if (state == RD_BURST) begin
            fill_valid <= 1'b1;
            fill_idx   <= beat;
            fill_data  <= wb_dat_i;
            if (!last_beat) begin
              beat     <= beat + IW'(1);
              wb_adr_o <= wb_adr_o + 32'd4;
              // next beat is the last one of the line
              if (beat == IW'(BEATS - 2)) wb_cti_o <= 3'b111;
            end
          end
        end else if (tmo_hit) begin
          abort_q <= 1'b1;
        end
      end else if (state == FINISH) begin
        done <= 1'b1;
        err  <= abort_q;
      end
    end
  end

endmodule

// File: tb/tb_wb_line_refill_master.sv
// Directed bench for wb_line_refill_master: scripted Wishbone slave plus
// hand-computed expectations checked on the falling edge.
module tb_wb_line_refill_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic        req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_sel;
  logic        fill_valid;
  logic [2:0]  fill_idx;
  logic [31:0] fill_data;
  logic        done, err;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic        wb_ack_i, wb_err_i, wb_rty_i;

  always #5 clk = ~clk;

  wb_line_refill_master #(.BEATS(8), .TIMEOUT(64), .MAX_RETRY(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
    .fill_valid(fill_valid), .fill_idx(fill_idx), .fill_data(fill_data),
    .done(done), .err(err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  localparam logic [1:0] R_NONE = 2'd0, R_ACK = 2'd1, R_ERR = 2'd2, R_RTY = 2'd3;

  logic [1:0]  resp [0:127];
  int          sc = 0, sc_base = 0;
  int          checks = 0, failures = 0;
  int          fv_cnt = 0;
  logic [2:0]  fv_last_idx = '0;
  logic [31:0] fv_last_data = '0;

  // Slave: the n-th strobed cycle of a request gets response resp[n]; read data is 0xA0 + beat.
  always @(negedge clk) begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_rty_i = 1'b0;
    wb_dat_i = 32'h0;
    if (wb_stb_o === 1'b1) begin
      case (resp[(sc - sc_base) % 128])
        R_ACK: begin
          wb_ack_i = 1'b1;
          wb_dat_i = 32'hA0 + {29'd0, wb_adr_o[4:2]};
        end
        R_ERR:   wb_err_i = 1'b1;
        R_RTY:   wb_rty_i = 1'b1;
        default: ;
      endcase
      sc++;
    end
  end

  always @(negedge clk) begin
    if (fill_valid === 1'b1) begin
      fv_cnt++;
      fv_last_idx  = fill_idx;
      fv_last_data = fill_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_resp(input int lo, input int hi, input logic [1:0] code);
    for (int i = lo; i <= hi; i++) resp[i] = code;
  endtask

  // Leaves the caller at the falling edge of the first cycle after accept.
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] s);
    @(negedge clk);
    chk("req_ready_before_issue", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    req_sel   = s;
    sc_base   = sc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    while (done !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  int n, fv0;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_sel = '0;
    set_resp(0, 127, R_NONE);
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_cti", {29'd0, wb_cti_o}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;

    // zero-wait line fill
    set_resp(0, 7, R_ACK);
    fv0 = fv_cnt;
    issue(1'b0, 32'h0000_1234, 32'h0, 4'h0);
    chk("f1_cyc", {31'd0, wb_cyc_o}, 32'd1);
    chk("f1_we", {31'd0, wb_we_o}, 32'd0);
    chk("f1_sel", {28'd0, wb_sel_o}, 32'hF);
    chk("f1_req_ready_busy", {31'd0, req_ready}, 32'd0);
    chk("f1_adr0", wb_adr_o, 32'h1220);
    chk("f1_cti0", {29'd0, wb_cti_o}, 32'd2);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk("f1_stb", {31'd0, wb_stb_o}, 32'd1);
      chk("f1_adr", wb_adr_o, 32'h1220 + 32'(4 * i));
      chk("f1_cti", {29'd0, wb_cti_o}, (i == 7) ? 32'd7 : 32'd2);
      chk("f1_fill_valid", {31'd0, fill_valid}, 32'd1);
      chk("f1_fill_idx", {29'd0, fill_idx}, 32'(i - 1));
      chk("f1_fill_data", fill_data, 32'hA0 + 32'(i - 1));
    end
    @(negedge clk);
    chk("f1_cyc_end", {31'd0, wb_cyc_o}, 32'd0);
    chk("f1_fill_idx7", {29'd0, fill_idx}, 32'd7);
    chk("f1_fill_data7", fill_data, 32'hA7);
    chk("f1_done_early", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("f1_done", {31'd0, done}, 32'd1);
    chk("f1_err", {31'd0, err}, 32'd0);
    chk("f1_ready_in_done", {31'd0, req_ready}, 32'd0);
    chk("f1_fill_count", 32'(fv_cnt - fv0), 32'd8);
    @(negedge clk);
    chk("f1_done_pulse", {31'd0, done}, 32'd0);
    chk("f1_ready_after", {31'd0, req_ready}, 32'd1);

    // single write, three wait states
    set_resp(0, 127, R_NONE);
    resp[3] = R_ACK;
    fv0 = fv_cnt;
    issue(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'b0011);
    chk("w_we", {31'd0, wb_we_o}, 32'd1);
    chk("w_adr", wb_adr_o, 32'h40);
    chk("w_dat", wb_dat_o, 32'hDEAD_BEEF);
    chk("w_sel", {28'd0, wb_sel_o}, 32'h3);
    chk("w_cti", {29'd0, wb_cti_o}, 32'd0);
    wait_done(20, n);
    chk("w_done_latency", 32'(n), 32'd5);
    chk("w_err", {31'd0, err}, 32'd0);
    chk("w_cyc_end", {31'd0, wb_cyc_o}, 32'd0);
    chk("w_no_fill", 32'(fv_cnt - fv0), 32'd0);

    // bus error on beat 3
    set_resp(0, 127, R_NONE);
    set_resp(0, 2, R_ACK);
    resp[3] = R_ERR;
    fv0 = fv_cnt;
    issue(1'b0, 32'h0000_1234, 32'h0, 4'h0);
    repeat (4) @(negedge clk);
    chk("e_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
    @(negedge clk);
    chk("e_done", {31'd0, done}, 32'd1);
    chk("e_err", {31'd0, err}, 32'd1);
    chk("e_fill_count", 32'(fv_cnt - fv0), 32'd3);
    chk("e_last_idx", {29'd0, fv_last_idx}, 32'd2);

    // two retries then success
    set_resp(0, 127, R_NONE);
    set_resp(0, 1, R_RTY);
    set_resp(2, 9, R_ACK);
    fv0 = fv_cnt;
    issue(1'b0, 32'h0000_2008, 32'h0, 4'h0);
    @(negedge clk);
    chk("r2_gap1", {31'd0, wb_cyc_o}, 32'd0);
    @(negedge clk);
    chk("r2_restart1_stb", {31'd0, wb_stb_o}, 32'd1);
    chk("r2_restart1_adr", wb_adr_o, 32'h2000);
    @(negedge clk);
    chk("r2_gap2", {31'd0, wb_cyc_o}, 32'd0);
    @(negedge clk);
    chk("r2_restart2_adr", wb_adr_o, 32'h2000);
    chk("r2_restart2_cti", {29'd0, wb_cti_o}, 32'd2);
    wait_done(30, n);
    chk("r2_done_latency", 32'(n), 32'd9);
    chk("r2_err", {31'd0, err}, 32'd0);
    chk("r2_fill_count", 32'(fv_cnt - fv0), 32'd8);
    chk("r2_last_data", fv_last_data, 32'hA7);

    // retries exhausted
    set_resp(0, 127, R_NONE);
    set_resp(0, 3, R_RTY);
    fv0 = fv_cnt;
    issue(1'b0, 32'h0000_2008, 32'h0, 4'h0);
    wait_done(30, n);
    chk("r4_done_latency", 32'(n), 32'd8);
    chk("r4_err", {31'd0, err}, 32'd1);
    chk("r4_no_fill", 32'(fv_cnt - fv0), 32'd0);

    // silent slave: ack timeout
    set_resp(0, 127, R_NONE);
    issue(1'b0, 32'h0000_3000, 32'h0, 4'h0);
    repeat (63) @(negedge clk);
    chk("t_stb_64th", {31'd0, wb_stb_o}, 32'd1);
    @(negedge clk);
    chk("t_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
    @(negedge clk);
    chk("t_done", {31'd0, done}, 32'd1);
    chk("t_err", {31'd0, err}, 32'd1);
    @(negedge clk);
    chk("t_ready_back", {31'd0, req_ready}, 32'd1);

    // reset during beat 5, then a clean fill
    set_resp(0, 127, R_NONE);
    set_resp(0, 7, R_ACK);
    issue(1'b0, 32'h0000_1234, 32'h0, 4'h0);
    repeat (5) @(negedge clk);
    chk("x_beat5_adr", wb_adr_o, 32'h1234);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("x_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("x_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("x_adr", wb_adr_o, 32'h0);
    chk("x_sel", {28'd0, wb_sel_o}, 32'h0);
    chk("x_cti", {29'd0, wb_cti_o}, 32'd0);
    chk("x_fill_valid", {31'd0, fill_valid}, 32'd0);
    chk("x_done", {31'd0, done}, 32'd0);
    chk("x_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    chk("x_no_done_after", {31'd0, done}, 32'd0);
    fv0 = fv_cnt;
    issue(1'b0, 32'h0000_1234, 32'h0, 4'h0);
    wait_done(30, n);
    chk("x2_done_latency", 32'(n), 32'd9);
    chk("x2_err", {31'd0, err}, 32'd0);
    chk("x2_fill_count", 32'(fv_cnt - fv0), 32'd8);
    chk("x2_last_idx", {29'd0, fv_last_idx}, 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
